// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES decryptor datapath.
// One plaintext block is 128 bits, bit 0 is the MSB of byte 0; it leaves as four 32-bit words.
package aes_dec_pkg;

  typedef logic [0:127] aes_block_t;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;

  // Word 0 is bits [0:31], i.e. the leading bytes of the block.
  function automatic logic [WORD_W-1:0] get_word(input aes_block_t blk, input logic [1:0] idx);
    return blk[WORD_W*idx +: WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit synchronous FIFO with occupancy count and full/empty flags.
// A push while full is accepted only if a pop happens in the same cycle.
module aes_blk_fifo
  import aes_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  aes_block_t       din_i,
  input  logic             pop_i,
  output aes_block_t       dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  aes_block_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale contents are unreachable once count is zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/aes_dec_pt_unpacker.sv
// Captures decrypted blocks on a rising pt_vld, buffers them and streams them out as 32-bit words.
// Stream handshake: a word moves on every clock0 edge where dout_vld & dout_rdy; while stalled, dout/dout_last hold.
module aes_dec_pt_unpacker
  import aes_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock0,
  input  logic             rst,
  input  aes_block_t       pt,
  input  logic             pt_vld,
  output logic [31:0]      dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_last,
  output logic             space_ok,
  output logic [CNT_W-1:0] fill_lvl,
  output logic             ovf,
  input  logic             clr_ovf
);

  logic       pt_vld_q;
  logic [1:0] word_idx_q, word_idx_d;
  logic       ovf_q, ovf_d;

  logic       push, xfer, pop, drop;
  logic       full, empty;
  aes_block_t head_blk;

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock0),
    .rst_i   (rst),
    .push_i  (push),
    .din_i   (pt),
    .pop_i   (pop),
    .dout_o  (head_blk),
    .count_o (fill_lvl),
    .full_o  (full),
    .empty_o (empty)
  );

  // The core cannot be stalled, so only the rising edge of pt_vld marks a new block.
  assign push = pt_vld & ~pt_vld_q;
  assign xfer = dout_vld & dout_rdy;
  assign pop  = xfer & (word_idx_q == 2'(WORDS_PER_BLOCK - 1));
  assign drop = push & full & ~pop;

  assign dout_vld  = ~empty;
  assign dout_last = dout_vld & (word_idx_q == 2'(WORDS_PER_BLOCK - 1));
  assign dout      = get_word(head_blk, word_idx_q);
  assign space_ok  = ~full;
  assign ovf       = ovf_q;

  always_comb begin
    word_idx_d = xfer ? word_idx_q + 2'd1 : word_idx_q;
    ovf_d      = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clock0) begin
    if (rst) begin
      pt_vld_q   <= 1'b0;
      word_idx_q <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      pt_vld_q   <= pt_vld;
      word_idx_q <= word_idx_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_pt_unpacker.sv
// Bench for aes_dec_pt_unpacker: expected words are queued when a block is driven and compared as they leave.
module tb_aes_dec_pt_unpacker;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock0 = 1'b0;
  logic             rst;
  logic [0:127]     pt;
  logic             pt_vld;
  logic [31:0]      dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             dout_last;
  logic             space_ok;
  logic [CNT_W-1:0] fill_lvl;
  logic             ovf;
  logic             clr_ovf;

  int n_checks = 0;
  int n_err    = 0;
  int n_xfer   = 0;

  // Each entry: {last flag, word}
  logic [32:0] exp_q[$];

  aes_dec_pt_unpacker #(.DEPTH(DEPTH)) dut (
    .clock0    (clock0),
    .rst       (rst),
    .pt        (pt),
    .pt_vld    (pt_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .dout_last (dout_last),
    .space_ok  (space_ok),
    .fill_lvl  (fill_lvl),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  // ---------------- clock ----------------
  always #5 clock0 = ~clock0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock0) begin
    if (!rst && dout_vld) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 64'(dout), 64'hdead_0000);
      end else begin
        check("dout_word", 64'({dout_last, dout}), 64'(exp_q[0]));
        if (dout_rdy) begin
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  task automatic expect_block(input logic [0:127] blk);
    logic [127:0] v;
    v = blk;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({(k == 3), 32'(v >> (32 * (3 - k)))});
  endtask

  function automatic logic [0:127] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One-cycle strobe followed by a low cycle so the next strobe is a fresh rising edge.
  task automatic push_block(input logic [0:127] blk, input bit accept);
    pt     = blk;
    pt_vld = 1'b1;
    if (accept) expect_block(blk);
    tick();
    pt_vld = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    dout_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_fill_empty"}, 64'(fill_lvl), 64'd0);
    check({tag, "_vld_low"}, 64'(dout_vld), 64'd0);
    dout_rdy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [0:127] blks [5];
  logic [0:127] c1_pt;
  int           x0;
  bit           rdy_seq [7];

  initial begin
    rst      = 1'b1;
    pt       = '0;
    pt_vld   = 1'b0;
    dout_rdy = 1'b0;
    clr_ovf  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_dout_vld", 64'(dout_vld), 64'd0);
    check("rst_dout_last", 64'(dout_last), 64'd0);
    check("rst_space_ok", 64'(space_ok), 64'd1);
    check("rst_fill_lvl", 64'(fill_lvl), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    // FIPS-197 C.1 plaintext streamed with the sink always ready
    c1_pt    = 128'h00112233_44556677_8899aabb_ccddeeff;
    dout_rdy = 1'b1;
    pt       = c1_pt;
    pt_vld   = 1'b1;
    expect_block(c1_pt);
    tick();
    pt_vld = 1'b0;
    check("c1_latency_vld", 64'(dout_vld), 64'd1);
    check("c1_first_word", 64'(dout), 64'h00112233);
    x0 = n_xfer;
    tick(); tick(); tick(); tick();
    check("c1_xfer_count", 64'(n_xfer - x0), 64'd4);
    check("c1_fill_after", 64'(fill_lvl), 64'd0);
    check("c1_vld_after", 64'(dout_vld), 64'd0);

    // Backpressure pattern
    dout_rdy = 1'b0;
    push_block(rand_block(), 1'b1);
    check("bp_fill_start", 64'(fill_lvl), 64'd1);
    rdy_seq = '{1, 0, 0, 1, 0, 1, 1};
    x0 = n_xfer;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) check("bp_fill_before_last", 64'(fill_lvl), 64'd1);
      dout_rdy = rdy_seq[i];
      tick();
    end
    dout_rdy = 1'b0;
    check("bp_xfer_count", 64'(n_xfer - x0), 64'd4);
    check("bp_fill_end", 64'(fill_lvl), 64'd0);

    // Overflow: five blocks into a four-deep buffer
    for (int i = 0; i < 5; i++) blks[i] = rand_block();
    for (int i = 0; i < 4; i++) push_block(blks[i], 1'b1);
    check("ovf_space_ok_full", 64'(space_ok), 64'd0);
    check("ovf_fill_full", 64'(fill_lvl), 64'd4);
    check("ovf_before", 64'(ovf), 64'd0);
    push_block(blks[4], 1'b0);
    check("ovf_set", 64'(ovf), 64'd1);
    check("ovf_fill_kept", 64'(fill_lvl), 64'd4);
    drain("ovf");
    check("ovf_sticky", 64'(ovf), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    check("ovf_space_ok_empty", 64'(space_ok), 64'd1);

    // Full boundary: push lands on the same edge as the pop of the last word
    for (int i = 0; i < 5; i++) blks[i] = rand_block();
    for (int i = 0; i < 4; i++) push_block(blks[i], 1'b1);
    dout_rdy = 1'b1;
    tick(); tick(); tick();
    check("bnd_last_pending", 64'(dout_last), 64'd1);
    pt     = blks[4];
    pt_vld = 1'b1;
    expect_block(blks[4]);
    tick();
    dout_rdy = 1'b0;
    pt_vld   = 1'b0;
    check("bnd_ovf", 64'(ovf), 64'd0);
    check("bnd_fill", 64'(fill_lvl), 64'd4);
    tick();
    drain("bnd");

    // Held strobe yields a single block
    pt     = rand_block();
    pt_vld = 1'b1;
    expect_block(pt);
    for (int i = 0; i < 6; i++) tick();
    pt_vld = 1'b0;
    tick();
    check("held_fill", 64'(fill_lvl), 64'd1);
    drain("held");

    // Reset in the middle of draining
    push_block(rand_block(), 1'b1);
    push_block(rand_block(), 1'b1);
    dout_rdy = 1'b1;
    tick(); tick();
    dout_rdy = 1'b0;
    blks[0] = rand_block();
    pt      = blks[0];
    pt_vld  = 1'b1;
    rst     = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    check("mid_rst_vld", 64'(dout_vld), 64'd0);
    check("mid_rst_fill", 64'(fill_lvl), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    expect_block(blks[0]);
    tick();
    pt_vld = 1'b0;
    check("post_rst_fill", 64'(fill_lvl), 64'd1);
    check("post_rst_word0", 64'(dout), 64'(blks[0][0:31]));
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_pt_unpacker.md
Name: aes_dec_pt_unpacker

Overview:
- Downstream stage of the 128-bit AES decryptor.
- Captures each 128-bit plaintext block `pt[0:127]` when the core signals `pt_vld`, with no backpressure to the core.
- Buffers blocks in a small FIFO and serialises them as 32-bit words over a valid/ready stream to the system bus side.
- Exposes a `space_ok` hint so integration can gate `ct_vld` into the decryptor and avoid overflow.

Parameters:
- DEPTH, 4: number of 128-bit blocks buffered. Power of two, ≥2.
- CNT_W, $clog2(DEPTH+1): width of `fill_lvl`. Derived; do not override.

Ports:
- clock0 in 1: single clock; all logic on posedge.
- rst in 1: synchronous, active-high reset.
- pt in 128: plaintext from decryptor, bit order [0:127]; bit 0 is the MSB of byte 0.
- pt_vld in 1: plaintext-valid from decryptor.
- dout out 32: serialised word.
- dout_vld out 1: `dout` valid.
- dout_rdy in 1: sink ready.
- dout_last out 1: high on the 4th (final) word of a block.
- space_ok out 1: FIFO holds fewer than DEPTH blocks.
- fill_lvl out CNT_W: blocks currently stored, including a partially drained one.
- ovf out 1: sticky overflow flag.
- clr_ovf in 1: clears `ovf`.

Behaviour:
- **Capture:**
  - A block is pushed on a clock edge where `pt_vld`=1 and the registered `pt_vld_d`=0, i.e. a rising edge of `pt_vld`.
  - `pt_vld` held high for several cycles yields exactly one push.
  - `pt` is sampled on that same edge.
- **Storage:**
  - DEPTH×128 register array with `wr_ptr`/`rd_ptr` (log2 DEPTH bits, natural wrap) and `count` (0..DEPTH).
- **Serialiser:**
  - 2-bit `word_idx`.
  - `dout` = `mem[rd_ptr]` word `word_idx`: word0 = `pt[0:31]`, word1 = `pt[32:63]`, word2 = `pt[64:95]`, word3 = `pt[96:127]`.
  - `dout_vld` = (`count`≠0).
  - `dout_last` = `dout_vld` & (`word_idx`==3).
- **Transfer:**
  - A word transfers on any edge with `dout_vld`&`dout_rdy`; `word_idx` then increments.
  - On transfer of word 3: `word_idx`→0, `rd_ptr`++, and the block is popped.
  - While `dout_vld`=1 and `dout_rdy`=0, `dout`/`dout_last` stay stable.
- **Latency:**
  - A block captured at edge N gives `dout_vld`=1 and word0 on `dout` in cycle N+1 when the FIFO was empty.
  - With `dout_rdy` held at 1, a block drains in 4 cycles.
- **Simultaneous push and pop:**
  - `count` is unchanged and both pointers advance.
  - At `count`==DEPTH, a push coinciding with the pop of word 3 is accepted and does not overflow.
- **Overflow:**
  - A push at `count`==DEPTH with no pop that cycle drops the incoming block.
  - `ovf` is set on the next edge; memory, pointers and `count` are untouched.
  - `ovf` stays 1 until `rst` or `clr_ovf`. If set and clear occur in the same cycle, set wins.
- **space_ok:** `count`<DEPTH (combinational from `count`).
- **fill_lvl:** `count`.
- **Reset values:**
  - `wr_ptr`, `rd_ptr`, `count`, `word_idx`, `pt_vld_d`, `ovf` = 0.
  - Therefore `dout_vld`=0, `dout_last`=0, `space_ok`=1, `fill_lvl`=0.
  - `dout` contents are don't-care while `dout_vld`=0; memory is not cleared.
- **Reset mid-block:**
  - Any partially drained block and all queued blocks are discarded.
  - A `pt_vld` rising edge in the reset cycle is ignored.
  - `pt_vld` still high on the cycle after reset deasserts counts as a rising edge, because `pt_vld_d` was cleared.

Decomposition:
- Shared package `aes_dec_pkg`:
  - `typedef logic [0:127] aes_block_t`.
  - `localparam WORDS_PER_BLOCK = 4`.
  - `localparam WORD_W = 32`.
- One natural sub-module, `aes_blk_fifo`: the DEPTH×128 synchronous FIFO with push/pop, `count` and `full`/`empty`.
- The top-level handles edge detection, the serialiser and overflow.

Test Plan:
1. FIPS-197 C.1: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a through the decryptor, `dout_rdy`=1 → words 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles, `dout_last`=1 only on ccddeeff.
2. Backpressure: one block, `dout_rdy` toggles 1,0,0,1,0,1,1 → each word held stable while stalled; exactly 4 transfers; `fill_lvl` 1→0 after the last.
3. Overflow: `dout_rdy`=0, push 5 distinct blocks → after the 4th, `space_ok`=0 and `fill_lvl`=4; after the 5th, `ovf`=1. Draining yields blocks 1–4 only. `clr_ovf` pulse → `ovf`=0.
4. Full-boundary: `count`=4, draining the final word of block 1 on the same edge as a new push → `ovf` stays 0, `fill_lvl` stays 4, the new block emerges last.
5. Held strobe: `pt_vld`=1 for 6 cycles → exactly one block queued (`fill_lvl`=1).
6. Reset mid-drain: 2 blocks queued, 2 words of the first sent, `rst` for 1 cycle → `dout_vld`=0, `fill_lvl`=0, `ovf`=0. The next block starts at word0.
